// File: rtl/mac_slot_scheduler_pkg.sv
// Shared definitions for the slotted-ALOHA scheduler: FSM encoding, Q window masks,
// default LFSR seed and the feedback tap positions that the tag and reader models share.
package mac_slot_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_SLOT_START = 3'd2,
        ST_RUN        = 3'd3,
        ST_GAP        = 3'd4
    } mac_state_e;

    localparam logic [15:0] MAC_SEED_DEFAULT = 16'h4C06;

    // Feedback taps for x^16+x^14+x^13+x^11+1 in the left-shifting arrangement
    localparam int TAP_A = 10;
    localparam int TAP_B = 12;
    localparam int TAP_C = 13;
    localparam int TAP_D = 15;

    function automatic logic [2:0] qToMask(input logic [1:0] q);
        case (q)
            2'd0:    qToMask = 3'b000;
            2'd1:    qToMask = 3'b001;
            2'd2:    qToMask = 3'b011;
            default: qToMask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/mac_slot_scheduler_if.sv
// Configuration and status bundle between the round controller and its host.
interface mac_slot_scheduler_if #(
    parameter int unsigned LEN_W = 16
);
    logic             enable;
    logic [1:0]       mac_q;
    logic [LEN_W-1:0] slot_len;
    logic [7:0]       slots_per_round;
    logic             mod_en;
    logic             slot_strobe;
    logic             round_done;
    logic             busy;
    logic [7:0]       slot_idx;
    logic [7:0]       tx_count;

    modport master (
        output enable, mac_q, slot_len, slots_per_round,
        input  mod_en, slot_strobe, round_done, busy, slot_idx, tx_count
    );

    modport slave (
        input  enable, mac_q, slot_len, slots_per_round,
        output mod_en, slot_strobe, round_done, busy, slot_idx, tx_count
    );
endinterface

// File: rtl/mac_slot_scheduler_lfsr_draw.sv
// Per-slot random draw: 16-bit LFSR plus the Q-windowed hit decision on the current value.
module mac_lfsr_draw
    import mac_slot_scheduler_pkg::*;
#(
    parameter logic [15:0] SEED = MAC_SEED_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_step,
    input  logic [1:0] i_q,
    output logic       o_hit
);

    logic [15:0] r_pn;
    logic        w_feedback;

    assign w_feedback = r_pn[TAP_A] ^ r_pn[TAP_B] ^ r_pn[TAP_C] ^ r_pn[TAP_D];

    // Decision uses the value before the step so the caller can register it in the same cycle
    assign o_hit = ~|(r_pn[2:0] & qToMask(i_q));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pn <= SEED;
        end else if (i_step) begin
            r_pn <= {r_pn[14:0], w_feedback};
        end
    end

endmodule

// File: rtl/mac_slot_scheduler.sv
// Slotted-ALOHA round controller: sequences slots and guard gaps, and gates the
// backscatter modulator with mod_en on slots chosen by the LFSR draw.
module mac_slot_scheduler
    import mac_slot_scheduler_pkg::*;
#(
    parameter logic [15:0] MAC_SEED     = MAC_SEED_DEFAULT,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned LEN_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mac_slot_scheduler_if.slave bus
);

    localparam logic [LEN_W-1:0] GUARD_LOAD =
        (GUARD_CYCLES == 0) ? '0 : LEN_W'(GUARD_CYCLES - 1);

    mac_state_e       r_state, w_nextState;
    logic [LEN_W-1:0] r_cnt, w_cntNext;
    logic [LEN_W-1:0] r_len;
    logic [7:0]       r_spr, r_slotIdx, r_txCount;
    logic [1:0]       r_q;
    logic             r_hit, r_modEn, r_slotStrobe, r_roundDone, r_busy;
    logic             w_hit, w_slotDone, w_lastSlot, w_abort, w_load, w_step, w_roundDoneNext;

    mac_lfsr_draw #(.SEED(MAC_SEED)) u_draw (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_step (w_step),
        .i_q    (r_q),
        .o_hit  (w_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nextState;
    end

    // Slot sequencing; dropping enable anywhere outside IDLE overrides the normal path
    always_comb begin
        w_nextState = r_state;
        w_cntNext   = r_cnt;
        w_slotDone  = 1'b0;
        case (r_state)
            ST_IDLE:       if (bus.enable) w_nextState = ST_LOAD;
            ST_LOAD:       w_nextState = ST_SLOT_START;
            ST_SLOT_START: begin
                w_nextState = ST_RUN;
                w_cntNext   = r_len - 1'b1;
            end
            ST_RUN: begin
                if (r_cnt == '0) begin
                    if (GUARD_CYCLES == 0) begin
                        w_slotDone = 1'b1;
                    end else begin
                        w_nextState = ST_GAP;
                        w_cntNext   = GUARD_LOAD;
                    end
                end else begin
                    w_cntNext = r_cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) w_slotDone = 1'b1;
                else             w_cntNext  = r_cnt - 1'b1;
            end
            default:       w_nextState = ST_IDLE;
        endcase
        w_lastSlot = (r_slotIdx == r_spr - 8'd1);
        if (w_slotDone) w_nextState = w_lastSlot ? ST_IDLE : ST_SLOT_START;
        w_abort = (r_state != ST_IDLE) && !bus.enable;
        if (w_abort) w_nextState = ST_IDLE;
        w_load          = (r_state == ST_LOAD) && !w_abort;
        w_step          = (r_state == ST_SLOT_START) && !w_abort;
        w_roundDoneNext = w_slotDone && w_lastSlot && !w_abort;
    end

    // Outputs are decoded from the next state so each flop lines up with the state it marks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_len        <= '0;
            r_spr        <= '0;
            r_q          <= '0;
            r_slotIdx    <= '0;
            r_txCount    <= '0;
            r_hit        <= 1'b0;
            r_modEn      <= 1'b0;
            r_slotStrobe <= 1'b0;
            r_roundDone  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_cnt        <= w_cntNext;
            r_modEn      <= (w_nextState == ST_RUN) && ((r_state == ST_SLOT_START) ? w_hit : r_hit);
            r_slotStrobe <= (w_nextState == ST_SLOT_START);
            r_roundDone  <= w_roundDoneNext;
            r_busy       <= (w_nextState != ST_IDLE);
            if (w_load) begin
                r_q       <= bus.mac_q;
                r_len     <= (bus.slot_len == '0) ? LEN_W'(1) : bus.slot_len;
                r_spr     <= (bus.slots_per_round == 8'd0) ? 8'd1 : bus.slots_per_round;
                r_slotIdx <= '0;
                r_txCount <= '0;
            end
            if (w_step) begin
                r_hit <= w_hit;
                if (w_hit && (r_txCount != 8'hFF)) r_txCount <= r_txCount + 8'd1;
            end
            if (w_slotDone && !w_lastSlot && !w_abort) r_slotIdx <= r_slotIdx + 8'd1;
        end
    end

    assign bus.mod_en      = r_modEn;
    assign bus.slot_strobe = r_slotStrobe;
    assign bus.round_done  = r_roundDone;
    assign bus.busy        = r_busy;
    assign bus.slot_idx    = r_slotIdx;
    assign bus.tx_count    = r_txCount;

endmodule

// File: doc/mac_slot_scheduler.md
Name: mac_slot_scheduler

Overview:
- Slotted-ALOHA round controller for the tag backscatter path.
- Divides each round into `slots_per_round` slots of `slot_len` cycles, each followed by a guard gap.
- Draws one pseudo-random decision per slot from an internal 16-bit LFSR, windowed by Q.
- Asserts `mod_en` for the full data portion of every selected slot; the modulator consumes `mod_en` as its gate.

Parameters:
- MAC_SEED, 16'h4C06, LFSR reset value.
- GUARD_CYCLES, 4, idle cycles after each slot's data portion (0 = no gap).
- LEN_W, 16, width of the slot length field.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  level; high requests rounds, low aborts.
- mac_q  in  2  window exponent; latched at round start.
- slot_len  in  LEN_W  data cycles per slot; latched at round start.
- slots_per_round  in  8  slots per round; latched at round start.
- mod_en  out  1  modulation window for the current slot.
- slot_strobe  out  1  one-cycle pulse at each slot start.
- round_done  out  1  one-cycle pulse when a round completes normally.
- busy  out  1  high in every state except IDLE.
- slot_idx  out  8  index of the current slot, 0-based.
- tx_count  out  8  number of selected slots in the current or last round.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE; pn = MAC_SEED.
  - All outputs and latched config are 0.
- LFSR:
  - Polynomial x^16+x^14+x^13+x^11+1.
  - Step is pn <= {pn[14:0], pn[10]^pn[12]^pn[13]^pn[15]}.
  - Advances only in SLOT_START, exactly once per slot.
  - Not reseeded between rounds or on abort; only rst_n reseeds.
- Selection mask from the latched Q: 0 -> 000, 1 -> 001, 2 -> 011, 3 -> 111.
- hit = ~|(pn[2:0] & mask), evaluated on pn before the step. Q=0 always hits.
- States: IDLE, LOAD, SLOT_START, RUN, GAP.
- IDLE:
  - busy = 0.
  - Goes to LOAD when enable = 1.
- LOAD (1 cycle):
  - Latches mac_q, slot_len and slots_per_round.
  - slot_len = 0 is latched as 1; slots_per_round = 0 is latched as 1.
  - Clears slot_idx and tx_count.
  - Goes to SLOT_START.
- SLOT_START (1 cycle):
  - slot_strobe = 1.
  - Registers hit; increments tx_count if hit (saturates at 255).
  - Steps the LFSR and loads the cycle counter.
  - Goes to RUN.
- RUN (slot_len cycles):
  - mod_en = registered hit.
  - Goes to GAP, or straight to the end-of-slot decision if GUARD_CYCLES = 0.
- GAP (GUARD_CYCLES cycles): mod_en = 0.
- End of slot:
  - If slot_idx = slots_per_round-1: round_done pulses for 1 cycle, aligned with entry to IDLE.
  - Otherwise slot_idx increments and the FSM goes to SLOT_START.
- Latency:
  - enable sampled high at edge t: LOAD at t+1, SLOT_START at t+2.
  - mod_en is high over cycles t+3 .. t+2+slot_len.
- Slot period = slot_len + GUARD_CYCLES + 1 cycles.
- Continuous operation:
  - With enable held high, IDLE lasts 1 cycle between rounds, then LOAD again.
  - tx_count holds the last round's value until that LOAD.
- Abort: enable = 0 in any non-IDLE state.
  - Next state is IDLE; mod_en, slot_strobe and busy are 0 from the next cycle.
  - No round_done pulse.
  - pn, tx_count and slot_idx hold their values.
- Config changes mid-round are ignored until the next LOAD.
- rst_n has priority over enable and over every state.
- Outputs are registered: mod_en, slot_strobe and round_done come from flops, with no combinational path from inputs.

Decomposition:
- Shared package holds:
  - the FSM state encoding (3-bit);
  - the Q-to-mask table;
  - MAC_SEED default;
  - LFSR tap positions.
- One natural sub-module, mac_lfsr_draw.
  - Contains the LFSR, step enable, q input and hit output.
  - Reuses the polynomial so the tag and reader models agree.
  - The FSM, counters and output flops stay in the top.

Test Plan:
- Reset then idle: hold rst_n = 0 for 3 cycles, enable = 0 -> all outputs 0, busy = 0, no strobes.
- Q=1 selection sequence: slot_len = 5, slots_per_round = 3, GUARD_CYCLES = 4, enable from reset.
  - Expected hits: slot0 hit (pn 4C06), slot1 miss (980D), slot2 hit (301A).
  - mod_en high for exactly 5 cycles in slots 0 and 2; tx_count = 2.
  - round_done is one pulse; slot_strobe spacing is 10 cycles.
- Q=0 and Q=3 from reset: Q=0 -> every slot hits. Q=3 -> first 3 slots miss, mod_en never high, tx_count = 0.
- Degenerate config: slot_len = 0, slots_per_round = 0 -> one slot of 1 mod_en cycle (Q=0), then round_done.
- Abort: drop enable on the 2nd RUN cycle of slot 1.
  - Next cycle: IDLE, mod_en = 0, busy = 0, no round_done.
  - Re-enable -> the next slot uses the continued LFSR (pn not reseeded).
- Mid-round config change: change mac_q and slot_len during RUN -> no effect until the following round's LOAD. Reset mid-round restores pn = 4C06.
